// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//  - 4-bit aluop encodings (ALU_PASS .. ALU_DIVU, two reserved codes)
//  - FSM state encoding for alu_mc
//  - iterative datapath mode select and the registered flag bundle
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_PASS = 4'b0000;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_NOT  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_INC  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_DEC  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_CLR  = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b1010;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1011;
    localparam logic [OP_W-1:0] ALU_MULU = 4'b1100;
    localparam logic [OP_W-1:0] ALU_DIVU = 4'b1101;
    localparam logic [OP_W-1:0] ALU_RSV0 = 4'b1110;
    localparam logic [OP_W-1:0] ALU_RSV1 = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_t;

    localparam logic ITER_MUL = 1'b0;
    localparam logic ITER_DIV = 1'b1;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic div_zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative datapath for unsigned multiply and divide.
//  load      : capture operands (a = multiplier / dividend, b = multiplicand / divisor)
//  step      : advance one iteration (one partial-product add or one restoring step)
//  mode      : ITER_MUL shift-add multiply, ITER_DIV restoring divide
//  hi, lo    : MUL -> {hi,lo} partial product; DIV -> hi remainder, lo quotient
//  hi_nxt_c, lo_nxt_c : value hi/lo take on the next step (lets the caller register
//                       the final result on the same edge as the last step)
module alu_mc_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_nxt_c,
    output logic [WIDTH-1:0] lo_nxt_c
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One iteration of either algorithm
    always_comb begin
        hi_nxt_c = hi_q;
        lo_nxt_c = lo_q;
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        shifted  = {hi_q, lo_q[WIDTH-1]};
        trial    = shifted - {1'b0, opnd_q};
        if (mode == ITER_MUL) begin
            // add multiplicand when multiplier LSB is set, then shift {carry,hi,lo} right
            hi_nxt_c = add_sum[WIDTH:1];
            lo_nxt_c = {add_sum[0], lo_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            // trial subtraction succeeded: keep difference, quotient bit 1
            hi_nxt_c = trial[WIDTH-1:0];
            lo_nxt_c = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            // restore: shifted remainder is below divisor so fits in WIDTH bits
            hi_nxt_c = shifted[WIDTH-1:0];
            lo_nxt_c = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand / accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
        end else if (step) begin
            hi_q   <= hi_nxt_c;
            lo_q   <= lo_nxt_c;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
//  Single-cycle logic/arith ops finish one cycle after accept; MULU and DIVU
//  (divisor non-zero) iterate WIDTH cycles in alu_mc_iter. One op in flight.
//  Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   op request handshake (aluop, A, B sampled at accept)
//   out_valid / out_ready result handshake
//   C, C_hi               result; MULU {C_hi,C}=A*B, DIVU C=quotient C_hi=remainder
//   zero                  A==B of the accepted op
//   overflow              signed overflow of ADD/SUB/INC/DEC
//   div_zero              DIVU with B==0
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] chi_q, chi_d;
    alu_flags_t       flags_q, flags_d;
    logic             eq_q, eq_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             iter_load;
    logic             iter_step;
    logic             iter_mode;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] iter_hi_nxt, iter_lo_nxt;

    logic [WIDTH-1:0] sum, diff, incr, decr;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             sc_flags_en;

    assign accept    = in_ready_q && in_valid && (state_q == ST_IDLE);
    assign iter_mode = (state_q == ST_DIV) ? ITER_DIV : ITER_MUL;

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .step     (iter_step),
        .mode     (iter_mode),
        .a        (A),
        .b        (B),
        .hi       (iter_hi),
        .lo       (iter_lo),
        .hi_nxt_c (iter_hi_nxt),
        .lo_nxt_c (iter_lo_nxt)
    );

    // Single-cycle result and overflow from the live operands
    always_comb begin
        sum         = A + B;
        diff        = A - B;
        incr        = A + WIDTH'(1);
        decr        = A - WIDTH'(1);
        sc_res      = '0;
        sc_ovf      = 1'b0;
        sc_flags_en = 1'b1;
        case (aluop)
            ALU_PASS: sc_res = A;
            ALU_AND:  sc_res = A & B;
            ALU_OR:   sc_res = A | B;
            ALU_NOT:  sc_res = ~A;
            ALU_XOR:  sc_res = A ^ B;
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = diff;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_INC: begin
                sc_res = incr;
                sc_ovf = (A == MAX_POS);
            end
            ALU_DEC: begin
                sc_res = decr;
                sc_ovf = (A == MIN_NEG);
            end
            ALU_CLR:  sc_res = '0;
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_MULU, ALU_DIVU: sc_res = '0;
            default: begin
                // reserved codes clear the result and raise no flags at all
                sc_res      = '0;
                sc_flags_en = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        chi_d     = chi_q;
        flags_d   = flags_q;
        eq_d      = eq_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    eq_d  = (A == B);
                    cnt_d = '0;
                    if (aluop == ALU_MULU) begin
                        state_d   = ST_MUL;
                        iter_load = 1'b1;
                    end else if (aluop == ALU_DIVU && B != '0) begin
                        state_d   = ST_DIV;
                        iter_load = 1'b1;
                    end else if (aluop == ALU_DIVU) begin
                        state_d = ST_DONE;
                        c_d     = '1;
                        chi_d   = A;
                        flags_d = '{zero: (A == B), overflow: 1'b0, div_zero: 1'b1};
                    end else begin
                        state_d = ST_DONE;
                        c_d     = sc_res;
                        chi_d   = '0;
                        flags_d = '{zero: sc_flags_en && (A == B), overflow: sc_ovf,
                                    div_zero: 1'b0};
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                iter_step = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    // capture the value the last step produces on this same edge
                    state_d = ST_DONE;
                    c_d     = iter_lo_nxt;
                    chi_d   = iter_hi_nxt;
                    flags_d = '{zero: eq_q, overflow: 1'b0, div_zero: 1'b0};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            c_q         <= '0;
            chi_q       <= '0;
            flags_q     <= '0;
            eq_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            chi_q       <= chi_d;
            flags_q     <= flags_d;
            eq_q        <= eq_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign C_hi      = chi_q;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;
    assign div_zero  = flags_q.div_zero;

endmodule
